// File: rtl/rv32im_pkg.sv
// Shared RV32IM constants: datapath width, M-extension divide funct3 codes
// and the divider FSM state type.
package rv32im_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : rv32im_pkg

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional macro DIV_FASTPATH_EN resolves divide-by-zero and signed overflow without iterating.
module div_unit #(
    parameter int unsigned XLEN = rv32im_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            wb_en_o
);
    import rv32im_pkg::*;

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    logic            in_signed, in_div0, in_ovf;
    logic [XLEN-1:0] in_special;
    logic [XLEN:0]   shifted, diff;
    logic            sub_ok;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix, final_res;

    always_comb begin
        in_signed = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        in_div0   = (rs2_i == '0);
        in_ovf    = in_signed && (rs1_i == SMIN) && (rs2_i == '1);
        // Overflow quotient equals rs1 itself (the most negative value).
        in_special = funct3_i[1] ? (in_div0 ? rs1_i : '0)
                                 : (in_div0 ? '1    : rs1_i);

        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_q};
        sub_ok  = ~diff[XLEN];
        rem_nx  = sub_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], sub_ok};

        quo_fix   = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fix   = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
        final_res = is_rem_q ? (div0_q ? rs1_q : (ovf_q ? '0   : rem_fix))
                             : (div0_q ? '1    : (ovf_q ? SMIN : quo_fix));

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        rs1_d     = rs1_q;
        result_d  = result_q;
        rd_d      = rd_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && funct3_i[2]) begin
                    state_d   = CALC;
                    cnt_d     = CW'(XLEN);
                    rem_d     = '0;
                    quo_d     = (in_signed && rs1_i[XLEN-1]) ? (~rs1_i + 1'b1) : rs1_i;
                    dvsr_d    = (in_signed && rs2_i[XLEN-1]) ? (~rs2_i + 1'b1) : rs2_i;
                    rs1_d     = rs1_i;
                    rd_d      = rd_addr_i;
                    is_rem_d  = funct3_i[1];
                    neg_quo_d = in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                    neg_rem_d = in_signed && rs1_i[XLEN-1];
                    div0_d    = in_div0;
                    ovf_d     = in_ovf;
`ifdef DIV_FASTPATH_EN
                    if (in_div0 || in_ovf) begin
                        state_d  = DONE;
                        result_d = in_special;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            rs1_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            rs1_q     <= rs1_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;
    assign wb_en_o   = done_o && (rd_q != 5'd0);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; special-case latency expectation follows DIV_FASTPATH_EN.
module tb_div_unit;

    localparam int LAT = 33;
`ifdef DIV_FASTPATH_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        wb_en_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .funct3_i  (funct3_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .rd_addr_i (rd_addr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o),
        .wb_en_o   (wb_en_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op from IDLE and observe the done cycle; lat = -1 if it never arrives.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic wb, output logic [4:0] rdo, output logic busy_at_done,
                          output logic done_after);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_addr_i = rd;
        @(posedge clk);
        lat = -1; res = 'x; wb = 1'bx; rdo = 'x; busy_at_done = 1'bx;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start_i = 1'b0;
            if (done_o) begin
                lat = n; res = result_o; wb = wb_en_o; rdo = rd_addr_o; busy_at_done = busy_o;
                break;
            end
        end
        @(negedge clk);
        done_after = done_o;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start_i = 1'b0; funct3_i = 3'b000;
        rs1_i = '0; rs2_i = '0; rd_addr_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy_o, done_o, wb_en_o} !== 3'b000 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b wb=%b result=%h rd=%0d, want all zero",
                     busy_o, done_o, wb_en_o, result_o, rd_addr_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_divu_remu();
        int lat; logic [31:0] res; logic wb, bd, da; logic [4:0] rdo;
        run_op(3'b101, 32'd100, 32'd7, 5'd5, lat, res, wb, rdo, bd, da);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL divu_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (res !== 32'd14) begin bad++; $display("FAIL divu_result: got %h want %h", res, 32'd14); end
        total++;
        if ({wb, rdo} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL divu_wb: wb=%b rd=%0d want wb=1 rd=5", wb, rdo);
        end
        total++;
        if ({bd, da} !== 2'b10) begin
            bad++; $display("FAIL divu_pulse: busy_at_done=%b done_next=%b want 1 0", bd, da);
        end
        total++;
        if (result_o !== 32'd14 || rd_addr_o !== 5'd5) begin
            bad++; $display("FAIL divu_hold: result=%h rd=%0d want 0000000e 5", result_o, rd_addr_o);
        end
        run_op(3'b111, 32'd100, 32'd7, 5'd5, lat, res, wb, rdo, bd, da);
        total++;
        if (lat !== LAT || res !== 32'd2) begin
            bad++; $display("FAIL remu: lat=%0d res=%h want lat=%0d res=00000002", lat, res, LAT);
        end
    endtask

    task automatic test_signed();
        logic [2:0]  f3 [3] = '{3'b100, 3'b110, 3'b110};
        logic [31:0] a  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] b  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] e  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
        int lat; logic [31:0] res; logic wb, bd, da; logic [4:0] rdo;
        for (int i = 0; i < 3; i++) begin
            run_op(f3[i], a[i], b[i], 5'd7, lat, res, wb, rdo, bd, da);
            total++;
            if (lat !== LAT || res !== e[i]) begin
                bad++;
                $display("FAIL signed_%0d: f3=%b lat=%0d res=%h want lat=%0d res=%h",
                         i, f3[i], lat, res, LAT, e[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [7] = '{3'b100, 3'b111, 3'b110, 3'b101, 3'b100, 3'b110, 3'b101};
        logic [31:0] a  [7] = '{32'd123, 32'd123, 32'hFFFF_FFF9, 32'd123,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [7] = '{32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e  [7] = '{32'hFFFF_FFFF, 32'd123, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'd0, 32'd0};
        int el [7] = '{SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, LAT};
        int lat; logic [31:0] res; logic wb, bd, da; logic [4:0] rdo;
        for (int i = 0; i < 7; i++) begin
            run_op(f3[i], a[i], b[i], 5'd9, lat, res, wb, rdo, bd, da);
            total++;
            if (lat !== el[i] || res !== e[i] || wb !== 1'b1 || da !== 1'b0) begin
                bad++;
                $display("FAIL special_%0d: lat=%0d res=%h wb=%b done_next=%b want lat=%0d res=%h wb=1 done_next=0",
                         i, lat, res, wb, da, el[i], e[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        int lat; logic [31:0] res; logic wb, bd, da; logic [4:0] rdo;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd4;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_i = 1'b1;
        #1;
        total++;
        if ({busy_o, done_o, wb_en_o} !== 3'b000 || result_o !== 32'h0) begin
            bad++; $display("FAIL abort_async: busy=%b done=%b wb=%b result=%h want 0 0 0 0",
                            busy_o, done_o, wb_en_o, result_o);
        end
        @(negedge clk); reset_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o || busy_o) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort_no_done: activity cycles=%0d want 0", seen); end
        run_op(3'b101, 32'd9, 32'd3, 5'd3, lat, res, wb, rdo, bd, da);
        total++;
        if (lat !== LAT || res !== 32'd3 || rdo !== 5'd3) begin
            bad++; $display("FAIL post_reset_divu: lat=%0d res=%h rd=%0d want lat=%0d res=00000003 rd=3",
                            lat, res, rdo, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        logic [31:0] res = 'x;
        logic [4:0]  rdo = 'x;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd5;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start_i = 1'b0;
            // Stray request with different operands held until the done cycle.
            if (n == 5) begin
                start_i = 1'b1; rs1_i = 32'd50; rs2_i = 32'd5; rd_addr_i = 5'd9;
            end
            if (done_o) begin lat = n; res = result_o; rdo = rd_addr_o; break; end
        end
        total++;
        if (lat !== LAT || res !== 32'd14 || rdo !== 5'd5) begin
            bad++; $display("FAIL stray_start: lat=%0d res=%h rd=%0d want lat=%0d res=0000000e rd=5",
                            lat, res, rdo, LAT);
        end
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL done_gap: busy=%b after DONE edge with start high, want 0", busy_o);
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rd0_illegal();
        int lat; logic [31:0] res; logic wb, bd, da; logic [4:0] rdo;
        int busy_seen = 0;
        run_op(3'b101, 32'd8, 32'd2, 5'd0, lat, res, wb, rdo, bd, da);
        total++;
        if (lat !== LAT || res !== 32'd4 || wb !== 1'b0) begin
            bad++; $display("FAIL rd0: lat=%0d res=%h wb=%b want lat=%0d res=00000004 wb=0", lat, res, wb, LAT);
        end
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd8; rs2_i = 32'd2; rd_addr_i = 5'd1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (busy_o !== 1'b0) busy_seen++;
        end
        start_i = 1'b0;
        total++;
        if (busy_seen !== 0) begin
            bad++; $display("FAIL illegal_funct3: busy cycles=%0d want 0", busy_seen);
        end
    endtask

    initial begin
        test_reset();
        test_divu_remu();
        test_signed();
        test_special();
        test_reset_abort();
        test_back_to_back();
        test_rd0_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_unit

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder execution unit; handles DIV, DIVU, REM and REMU.
- Sits directly downstream of the register file: consumes the rs1/rs2 read data and destination index.
- Produces a write-back value, index and enable for the register file's rd write port.
- Control stalls the PC while busy_o is high. Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- funct3_i  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
- rs1_i  input  XLEN  dividend (register file rs1_o)
- rs2_i  input  XLEN  divisor (register file rs2_o)
- rd_addr_i  input  5  destination register index
- busy_o  output  1  high from the accepting edge until done_o deasserts
- done_o  output  1  one-cycle pulse; result_o valid in that cycle
- result_o  output  XLEN  quotient or remainder
- rd_addr_o  output  5  captured destination index
- wb_en_o  output  1  done_o AND (rd_addr_o != 0); drives the register file write_enable_i

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; busy_o, done_o, wb_en_o, result_o, rd_addr_o and all internal registers go to 0.
- Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE to CALC (edge E0):
  - Condition: start_i=1 and funct3_i[2]=1.
  - Captures |rs1|, |rs2| (signed ops only), op, sign flags and rd_addr_i.
  - Clears the partial remainder; loads counter = XLEN.
  - start_i with funct3_i[2]=0 is ignored.
- CALC, each edge:
  - Shift {rem, quo} left 1, trial-subtract the divisor.
  - If non-negative, keep the difference and set quo[0]=1.
  - Decrement the counter. When it reaches 0 (edge E32), apply sign fix-up and load result_o, then go to DONE.
- DONE:
  - done_o=1 for exactly one cycle (between E32 and E33); busy_o stays 1.
  - Next edge returns to IDLE; start_i can be accepted at that same edge only if the state is already IDLE. Back-to-back issue therefore has a one-cycle gap.
- Latency: done_o high in the 33rd cycle after the accepting edge, i.e. 32 CALC edges plus the DONE cycle.
- start_i while busy: ignored; captured operands are unaffected by input changes after E0.
- Sign rules:
  - Quotient is negated when the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
  - Unsigned ops use raw operands.
- Special cases (exact RISC-V values):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- result_o and rd_addr_o hold their last values until the next DONE.
- All arithmetic is XLEN+1 bits for the trial subtract; no other widening.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- Defined:
  - Divide-by-zero and signed overflow are detected at E0; the unit goes IDLE to DONE directly with the special result loaded.
  - done_o is high in the cycle after E0 (latency 1).
- Not defined:
  - Special cases run the full 32 CALC iterations.
  - The special result is forced at the final edge; latency is identical to normal ops.
- Results are bit-identical either way.

Decomposition:
- Shared package rv32im_pkg:
  - XLEN constant.
  - funct3 constants F3_DIV/F3_DIVU/F3_REM/F3_REMU.
  - Divider state enum typedef (IDLE, CALC, DONE).
- No sub-module: sign conditioning and the iteration datapath stay inline in div_unit.

Test Plan:
- DIVU rs1=100, rs2=7, rd=5 -> done_o exactly 33 cycles after the accepting edge; result_o=14; wb_en_o=1; rd_addr_o=5. Repeat as REMU -> 2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REM rs1=7, rs2=-2 -> 1.
- DIV rs1=123, rs2=0 -> 0xFFFFFFFF; REMU rs1=123, rs2=0 -> 123. With DIV_FASTPATH_EN, done_o is high the cycle after acceptance; without it, after 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Reset and stray requests:
  - Assert reset_i asynchronously mid-CALC (cycle 10) -> busy_o/done_o drop immediately; no done pulse.
  - A new DIVU 9/3 after release -> 3.
  - start_i pulsed while busy with different operands -> ignored; original result unchanged.
- rd_addr_i=0, DIVU 8/2 -> done_o=1, result_o=4, wb_en_o=0. funct3_i=000 with start_i=1 -> stays IDLE; busy_o stays 0.
